uart_tx_fifo_encoder: RTL and testbench

//  Parametrised UART transmitter: successor to the single-byte encoder.
//  - Adds a write FIFO, configurable data width, optional parity and 1/2 stop bits.
//  - Keeps the runtime bit period input.
//  - Sits between byte producers (CPU/regs, test pattern gens) and the board TX pin.
//  - Frames stream back-to-back with no idle gap while the FIFO holds data.

---
 rtl/uart_tx_fifo_encoder_if.sv | 14 +
 rtl/uart_tx_fifo_encoder.sv | 155 +++++++++++++++
 tb/tb_uart_tx_fifo_encoder.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_encoder_if.sv
// rtl/uart_tx_fifo_encoder_if.sv - FIFO write-side bundle for uart_tx_fifo_encoder
interface uart_tx_fifo_encoder_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
);
  logic [DATA_BITS-1:0]        i_Data;
  logic                        i_write_enable;
  logic                        o_full;
  logic [$clog2(FIFO_DEPTH):0] o_count;
  logic                        o_overflow;

  modport master (output i_Data, i_write_enable, input o_full, o_count, o_overflow);
  modport slave  (input i_Data, i_write_enable, output o_full, o_count, o_overflow);
endinterface

// File: rtl/uart_tx_fifo_encoder.sv
// rtl/uart_tx_fifo_encoder.sv - UART transmitter with write FIFO, optional parity and 1/2 stop bits
module uart_tx_fifo_encoder #(
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4,
  parameter int PERIOD_WIDTH = 20
) (
  input  logic                    i_Clk,
  input  logic                    i_Reset,
  input  logic [PERIOD_WIDTH-1:0] i_Period,
  uart_tx_fifo_encoder_if.slave   wr_if,
  output logic                    o_UART_TX,
  output logic                    o_busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
  localparam logic HAS_PAR = (PARITY_MODE != 0);
  localparam logic PAR_ODD = (PARITY_MODE == 2);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic [DATA_BITS-1:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0]           r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]           r_count;
  logic                    r_overflow;
  state_t                  r_state, w_state_next;
  logic [PERIOD_WIDTH-1:0] r_cnt, w_cnt_next;
  logic [PERIOD_WIDTH-1:0] r_period, w_period_next;
  logic [BW-1:0]           r_bit_cnt, w_bit_next;
  logic [DATA_BITS-1:0]    r_shift, w_shift_next;
  logic                    r_parity, w_parity_next;
  logic                    r_tx, w_tx_next;
  logic                    w_pop, w_full, w_empty, w_accept, w_bit_done;
  logic [DATA_BITS-1:0]    w_head;
  logic [PERIOD_WIDTH-1:0] w_period_in;

  assign w_full      = (r_count == CW'(FIFO_DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_accept    = wr_if.i_write_enable && !w_full;
  assign w_head      = r_mem[r_rd_ptr];
  assign w_bit_done  = (r_cnt == r_period - PERIOD_WIDTH'(1));
  assign w_period_in = (i_Period == '0) ? PERIOD_WIDTH'(1) : i_Period;

  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt + PERIOD_WIDTH'(1);
    w_bit_next    = r_bit_cnt;
    w_shift_next  = r_shift;
    w_parity_next = r_parity;
    w_period_next = r_period;
    w_tx_next     = r_tx;
    w_pop         = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_next = '0;
        w_pop      = !w_empty;
      end
      S_START: if (w_bit_done) begin
        w_state_next = S_DATA;
        w_cnt_next   = '0;
        w_bit_next   = '0;
        w_tx_next    = r_shift[0];
        w_shift_next = r_shift >> 1;
      end
      S_DATA: if (w_bit_done) begin
        w_cnt_next = '0;
        if (r_bit_cnt == LAST_DATA) begin
          w_bit_next = '0;
          if (HAS_PAR) begin
            w_state_next = S_PARITY;
            w_tx_next    = r_parity;
          end else begin
            w_state_next = S_STOP;
            w_tx_next    = 1'b1;
          end
        end else begin
          w_bit_next   = r_bit_cnt + BW'(1);
          w_tx_next    = r_shift[0];
          w_shift_next = r_shift >> 1;
        end
      end
      S_PARITY: if (w_bit_done) begin
        w_state_next = S_STOP;
        w_cnt_next   = '0;
        w_bit_next   = '0;
        w_tx_next    = 1'b1;
      end
      S_STOP: if (w_bit_done) begin
        w_cnt_next = '0;
        if (r_bit_cnt == LAST_STOP) begin
          if (w_empty) w_state_next = S_IDLE;
          else         w_pop        = 1'b1;
        end else begin
          w_bit_next = r_bit_cnt + BW'(1);
        end
      end
      default: w_state_next = S_IDLE;
    endcase
    // A pop always launches a fresh frame: the start bit goes out on this same edge.
    if (w_pop) begin
      w_state_next  = S_START;
      w_cnt_next    = '0;
      w_shift_next  = w_head;
      w_parity_next = (^w_head) ^ PAR_ODD;
      w_period_next = w_period_in;
      w_tx_next     = 1'b0;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_period   <= PERIOD_WIDTH'(1);
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_parity   <= 1'b0;
      r_tx       <= 1'b1;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_period   <= w_period_next;
      r_bit_cnt  <= w_bit_next;
      r_shift    <= w_shift_next;
      r_parity   <= w_parity_next;
      r_tx       <= w_tx_next;
      r_overflow <= wr_if.i_write_enable && w_full;
      if (w_accept) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)    r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_Clk) begin
    if (w_accept) r_mem[r_wr_ptr] <= wr_if.i_Data;
  end

  assign o_UART_TX        = r_tx;
  assign o_busy           = (r_state != S_IDLE) || !w_empty;
  assign wr_if.o_full     = w_full;
  assign wr_if.o_count    = r_count;
  assign wr_if.o_overflow = r_overflow;
endmodule

// File: tb/tb_uart_tx_fifo_encoder.sv
// tb/tb_uart_tx_fifo_encoder.sv - self-checking bench: three parity/stop/width variants against a frame-level model
module tb_uart_tx_fifo_encoder;
  logic        clk;
  logic        tb_reset;
  logic [19:0] tb_period;
  logic        tb_we;
  logic [7:0]  tb_data;

  logic        tx0, tx1, tx2, busy0, busy1, busy2;
  logic        d_tx [3];
  logic        d_busy [3];
  logic        d_full [3];
  logic        d_ovf [3];
  logic [2:0]  d_cnt [3];

  uart_tx_fifo_encoder_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) if0 ();
  uart_tx_fifo_encoder_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) if1 ();
  uart_tx_fifo_encoder_if #(.DATA_BITS(7), .FIFO_DEPTH(4)) if2 ();

  assign if0.i_Data = tb_data;
  assign if1.i_Data = tb_data;
  assign if2.i_Data = tb_data[6:0];
  assign if0.i_write_enable = tb_we;
  assign if1.i_write_enable = tb_we;
  assign if2.i_write_enable = tb_we;

  uart_tx_fifo_encoder #(.DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(4), .PERIOD_WIDTH(20)) dut0 (
    .i_Clk(clk), .i_Reset(tb_reset), .i_Period(tb_period), .wr_if(if0), .o_UART_TX(tx0), .o_busy(busy0));
  uart_tx_fifo_encoder #(.DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(2), .FIFO_DEPTH(4), .PERIOD_WIDTH(20)) dut1 (
    .i_Clk(clk), .i_Reset(tb_reset), .i_Period(tb_period), .wr_if(if1), .o_UART_TX(tx1), .o_busy(busy1));
  uart_tx_fifo_encoder #(.DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(1), .FIFO_DEPTH(4), .PERIOD_WIDTH(20)) dut2 (
    .i_Clk(clk), .i_Reset(tb_reset), .i_Period(tb_period), .wr_if(if2), .o_UART_TX(tx2), .o_busy(busy2));

  assign d_tx[0] = tx0;   assign d_tx[1] = tx1;   assign d_tx[2] = tx2;
  assign d_busy[0] = busy0; assign d_busy[1] = busy1; assign d_busy[2] = busy2;
  assign d_full[0] = if0.o_full; assign d_full[1] = if1.o_full; assign d_full[2] = if2.o_full;
  assign d_ovf[0] = if0.o_overflow; assign d_ovf[1] = if1.o_overflow; assign d_ovf[2] = if2.o_overflow;
  assign d_cnt[0] = if0.o_count; assign d_cnt[1] = if1.o_count; assign d_cnt[2] = if2.o_count;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // Model: FIFO as a circular list of words; an active frame is a list of line bits, each held per clocks.
  int cfg_db [3] = '{8, 8, 7};
  int cfg_par [3] = '{0, 1, 2};
  int cfg_stop [3] = '{1, 2, 1};
  logic [7:0]  m_mem [3][4];
  int          m_head [3] = '{0, 0, 0};
  int          m_cnt [3] = '{0, 0, 0};
  bit          m_act [3] = '{0, 0, 0};
  int          m_pos [3] = '{0, 0, 0};
  int          m_per [3] = '{1, 1, 1};
  int          m_nb [3] = '{0, 0, 0};
  logic [15:0] m_bits [3];
  logic        e_ovf [3] = '{0, 0, 0};

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      logic       full;
      logic [7:0] w;
      logic       p;
      int         n;
      if (tb_reset) begin
        m_cnt[k] = 0; m_head[k] = 0; m_act[k] = 0; e_ovf[k] = 0;
      end else begin
        full = (m_cnt[k] == 4);
        e_ovf[k] = tb_we && full;
        if (m_act[k]) begin
          m_pos[k]++;
          if (m_pos[k] == m_nb[k] * m_per[k]) m_act[k] = 0;
        end
        if (!m_act[k] && m_cnt[k] > 0) begin
          w = m_mem[k][m_head[k]];
          m_head[k] = (m_head[k] + 1) % 4;
          m_cnt[k]--;
          m_bits[k] = '0;
          p = 1'b0;
          for (int i = 0; i < cfg_db[k]; i++) begin
            m_bits[k][1 + i] = w[i];
            p = p ^ w[i];
          end
          n = 1 + cfg_db[k];
          if (cfg_par[k] != 0) begin
            m_bits[k][n] = (cfg_par[k] == 2) ? ~p : p;
            n++;
          end
          for (int s = 0; s < cfg_stop[k]; s++) begin
            m_bits[k][n] = 1'b1;
            n++;
          end
          m_nb[k] = n;
          m_per[k] = (tb_period == 0) ? 1 : int'(tb_period);
          m_pos[k] = 0;
          m_act[k] = 1;
        end
        if (tb_we && !full) begin
          m_mem[k][(m_head[k] + m_cnt[k]) % 4] = tb_data;
          m_cnt[k]++;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("tx%0d", k), int'(d_tx[k]), m_act[k] ? int'(m_bits[k][m_pos[k] / m_per[k]]) : 1);
      chk($sformatf("busy%0d", k), int'(d_busy[k]), (m_act[k] || m_cnt[k] > 0) ? 1 : 0);
      chk($sformatf("count%0d", k), int'(d_cnt[k]), m_cnt[k]);
      chk($sformatf("full%0d", k), int'(d_full[k]), (m_cnt[k] == 4) ? 1 : 0);
      chk($sformatf("overflow%0d", k), int'(d_ovf[k]), int'(e_ovf[k]));
    end
  endtask

  task automatic step(input logic we, input logic [7:0] d);
    tb_we = we;
    tb_data = d;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int n;
    n = 0;
    while ((d_busy[0] || d_busy[1] || d_busy[2]) && n < budget) begin
      step(1'b0, 8'h00);
      n++;
    end
    if (n >= budget) chk({nm, "_idle_timeout"}, 1, 0);
  endtask

  typedef struct {
    logic       we;
    logic [7:0] data;
    logic       tx;
    logic       busy;
    int         cnt;
  } vec_t;
  vec_t vecs [22];

  initial begin
    logic [9:0] t1_bits;
    int c;
    t1_bits = 10'b1100010100;
    vecs[0] = '{we: 1'b1, data: 8'h8A, tx: 1'b1, busy: 1'b1, cnt: 1};
    for (int i = 0; i < 20; i++) vecs[1 + i] = '{we: 1'b0, data: 8'h00, tx: t1_bits[i / 2], busy: 1'b1, cnt: 0};
    vecs[21] = '{we: 1'b0, data: 8'h00, tx: 1'b1, busy: 1'b0, cnt: 0};

    tb_reset = 1'b1; tb_period = 20'd2; tb_we = 1'b0; tb_data = 8'h00;
    step(1'b0, 8'h00);
    step(1'b1, 8'hFF);
    tb_reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_tx%0d", k), int'(d_tx[k]), 1);
      chk($sformatf("rst_busy%0d", k), int'(d_busy[k]), 0);
      chk($sformatf("rst_count%0d", k), int'(d_cnt[k]), 0);
      chk($sformatf("rst_full%0d", k), int'(d_full[k]), 0);
      chk($sformatf("rst_ovf%0d", k), int'(d_ovf[k]), 0);
    end

    // 0x8A at P=2 on the plain 8N1 instance
    tb_period = 20'd2;
    for (int i = 0; i < 22; i++) begin
      step(vecs[i].we, vecs[i].data);
      chk($sformatf("t1_tx[%0d]", i), int'(tx0), int'(vecs[i].tx));
      chk($sformatf("t1_busy[%0d]", i), int'(busy0), int'(vecs[i].busy));
      chk($sformatf("t1_cnt[%0d]", i), int'(d_cnt[0]), vecs[i].cnt);
    end
    wait_idle("t1", 100);

    // parity placement and two stop bits, 0x07 at P=2
    step(1'b1, 8'h07);
    for (int c2 = 0; c2 < 26; c2++) begin
      step(1'b0, 8'h00);
      if (c2 == 18 || c2 == 19) chk("t2_even_parity", int'(tx1), 1);
      if (c2 == 16 || c2 == 17) chk("t2_odd_parity", int'(tx2), 0);
      if (c2 >= 20 && c2 <= 23) chk("t2_stop2_high", int'(tx1), 1);
      if (c2 == 23) chk("t2_stop2_busy", int'(busy1), 1);
      if (c2 == 24) chk("t2_stop2_done", int'(busy1), 0);
      if (c2 == 19) chk("t2_8n1_busy", int'(busy0), 1);
      if (c2 == 20) chk("t2_8n1_done", int'(busy0), 0);
    end
    wait_idle("t2", 100);

    // three back-to-back frames at P=3
    tb_period = 20'd3;
    step(1'b1, 8'h55);
    step(1'b1, 8'hAA);
    step(1'b1, 8'h0F);
    c = 1;
    while (busy0 && c < 200) begin
      step(1'b0, 8'h00);
      c++;
    end
    chk("t3_total_clocks", c, 90);
    wait_idle("t3", 300);

    // overflow: six writes with a depth-4 FIFO
    tb_period = 20'd1;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 8'($urandom));
      if (i == 4) chk("t4_full", int'(d_full[0]), 1);
      if (i == 4) chk("t4_count", int'(d_cnt[0]), 4);
      if (i == 5) chk("t4_overflow", int'(d_ovf[0]), 1);
    end
    step(1'b0, 8'h00);
    chk("t4_overflow_clear", int'(d_ovf[0]), 0);
    c = 5;
    while (busy0 && c < 200) begin
      step(1'b0, 8'h00);
      c++;
    end
    chk("t4_five_frames", c, 50);
    wait_idle("t4", 300);

    // reset in the middle of data bit 3
    tb_period = 20'd2;
    step(1'b1, 8'hC3);
    for (int c5 = 0; c5 < 10; c5++) begin
      step(1'b0, 8'h00);
      if (c5 == 8) chk("t5_bit3", int'(tx0), 0);
    end
    tb_reset = 1'b1;
    step(1'b0, 8'h00);
    tb_reset = 1'b0;
    chk("t5_rst_tx", int'(tx0), 1);
    chk("t5_rst_busy", int'(busy0), 0);
    chk("t5_rst_count", int'(d_cnt[0]), 0);
    step(1'b1, 8'h3C);
    wait_idle("t5", 100);

    // period change mid-frame, then period 0
    tb_period = 20'd2;
    step(1'b1, 8'hA5);
    step(1'b1, 8'h5A);
    step(1'b0, 8'h00);
    tb_period = 20'd4;
    c = 1;
    while (busy0 && c < 200) begin
      step(1'b0, 8'h00);
      c++;
    end
    chk("t6_period_change", c, 60);
    wait_idle("t6a", 200);
    tb_period = 20'd0;
    step(1'b1, 8'h3E);
    c = -1;
    while (busy0 && c < 100) begin
      step(1'b0, 8'h00);
      c++;
    end
    chk("t6_period_zero", c, 10);
    wait_idle("t6b", 100);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      if (i % 60 == 0) tb_period = 20'($urandom_range(0, 3));
      tb_reset = ($urandom_range(0, 299) == 0);
      step($urandom_range(0, 3) == 0, 8'($urandom));
    end
    tb_reset = 1'b0;
    wait_idle("rand", 500);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
